// File: rtl/i2s_receiver.sv
// I2S ADC capture: generates MCLK/SCK/LRCK from a free-running divider and deserialises 16-bit stereo pairs.
// Optional peak meter on the level port is enabled by defining I2S_RX_PEAK_EN.
module i2s_receiver #(
   parameter int unsigned PEAK_WIN_LOG2 = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdin,
   output logic        MCLK,
   output logic        SCK,
   output logic        LRCK,
   output logic [15:0] left_sample,
   output logic [15:0] right_sample,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        overrun,
   output logic [3:0]  level
);

   logic [8:0]  cnt_q, cnt_d;
   logic        mclk_q, mclk_d, sck_q, sck_d, lrck_q, lrck_d;
   logic        sdin_q;
   logic [15:0] shift_q, shift_d;
   logic [15:0] stage_q, stage_d;
   logic [15:0] left_q, left_d, right_q, right_d;
   logic        primed_q, primed_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;
   logic        capture, left_done, pair_load, xfer;

   // NOTE: every signal assigned here gets a value on every path, so no latches are inferred.
   always_comb begin
      cnt_d     = cnt_q + 9'd1;
      // Clock pins are registered copies of the next divider value, so they track cnt_q exactly.
      mclk_d    = cnt_d[1];
      sck_d     = cnt_d[3];
      lrck_d    = cnt_d[8];
      capture   = (cnt_q[3:0] == 4'd8);
      left_done = capture && cnt_q[8] && (cnt_q[7:4] == 4'd0);
      pair_load = capture && !cnt_q[8] && (cnt_q[7:4] == 4'd0) && primed_q;
      xfer      = valid_q && sample_ready;
      shift_d   = capture ? {shift_q[14:0], sdin_q} : shift_q;
      stage_d   = left_done ? shift_d : stage_q;
      primed_d  = primed_q || left_done;
      left_d    = pair_load ? stage_q : left_q;
      right_d   = pair_load ? shift_d : right_q;
      valid_d   = pair_load || (valid_q && !xfer);
      overrun_d = overrun_q || (pair_load && valid_q && !xfer);
   end

`ifdef I2S_RX_PEAK_EN
   logic [PEAK_WIN_LOG2-1:0] frame_q, frame_d;
   logic [14:0]              peak_q, peak_d, peak_upd, mag_l, mag_r;
   logic [3:0]               level_q, level_d;

   function automatic logic [14:0] mag(input logic [15:0] x);
      logic [15:0] neg;
      neg = -x;
      if (x == 16'h8000) return 15'h7FFF;
      else if (x[15])    return neg[14:0];
      else               return x[14:0];
   endfunction

   always_comb begin
      mag_l    = mag(stage_q);
      mag_r    = mag(shift_d);
      peak_upd = peak_q;
      if (mag_l > peak_upd) peak_upd = mag_l;
      if (mag_r > peak_upd) peak_upd = mag_r;
      frame_d  = frame_q;
      peak_d   = peak_q;
      level_d  = level_q;
      if (pair_load) begin
         frame_d = frame_q + 1'b1;
         if (frame_q == '1) begin
            level_d = peak_upd[14:11];
            peak_d  = '0;
         end else begin
            peak_d  = peak_upd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= '0;
         peak_q  <= '0;
         level_q <= '0;
      end else begin
         frame_q <= frame_d;
         peak_q  <= peak_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
`else
   assign level = 4'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         mclk_q    <= 1'b0;
         sck_q     <= 1'b0;
         lrck_q    <= 1'b0;
         sdin_q    <= 1'b0;
         shift_q   <= '0;
         stage_q   <= '0;
         left_q    <= '0;
         right_q   <= '0;
         primed_q  <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         mclk_q    <= mclk_d;
         sck_q     <= sck_d;
         lrck_q    <= lrck_d;
         sdin_q    <= sdin;
         shift_q   <= shift_d;
         stage_q   <= stage_d;
         left_q    <= left_d;
         right_q   <= right_d;
         primed_q  <= primed_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign MCLK         = mclk_q;
   assign SCK          = sck_q;
   assign LRCK         = lrck_q;
   assign left_sample  = left_q;
   assign right_sample = right_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an I2S ADC model drives sdin from a reference frame counter,
// and each expectation is a hand-computed constant checked with an immediate assertion.
module tb_i2s_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sdin = 1'b0;
   logic        sample_ready = 1'b0;
   logic        MCLK, SCK, LRCK, sample_valid, overrun;
   logic [15:0] left_sample, right_sample;
   logic [3:0]  level;

   int n_pass  = 0;
   int n_total = 0;
   int clk_err = 0;

   logic [8:0]  tcnt = '0;
   logic [15:0] l_word = 16'h0000, r_word = 16'h0000;
   logic [15:0] l_tx = 16'h0000, r_tx = 16'h0000;

`ifdef I2S_RX_PEAK_EN
   localparam logic [15:0] LVL_A = 16'd15;
   localparam logic [15:0] LVL_B = 16'd1;
`else
   localparam logic [15:0] LVL_A = 16'd0;
   localparam logic [15:0] LVL_B = 16'd0;
`endif

   i2s_receiver #(.PEAK_WIN_LOG2(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .sdin         (sdin),
      .MCLK         (MCLK),
      .SCK          (SCK),
      .LRCK         (LRCK),
      .left_sample  (left_sample),
      .right_sample (right_sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .level        (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // One clk edge; afterwards tcnt equals the DUT divider, and sdin carries the slot bit for it.
   task automatic tick();
      logic r;
      int   b;
      r = rst;
      @(posedge clk);
      #1;
      tcnt = r ? 9'd0 : tcnt + 9'd1;
      if (!r && tcnt == 9'd16) begin
         l_tx = l_word;
         r_tx = r_word;
      end
      b = int'(tcnt[7:4]);
      if (b != 0) sdin = tcnt[8] ? r_tx[16 - b] : l_tx[16 - b];
      else        sdin = tcnt[8] ? l_tx[0] : r_tx[0];
      if (MCLK !== tcnt[1] || SCK !== tcnt[3] || LRCK !== tcnt[8]) clk_err++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      l_word = 16'hA5C3;
      r_word = 16'h1234;
      run(3);
      check("rst_valid",   {15'd0, sample_valid}, 16'd0);
      check("rst_overrun", {15'd0, overrun},      16'd0);
      check("rst_left",    left_sample,           16'd0);
      check("rst_right",   right_sample,          16'd0);
      check("rst_clocks",  {13'd0, MCLK, SCK, LRCK}, 16'd0);
      rst = 1'b0;

      // First pair (frame 0) loads on the 521st edge after reset is released.
      run(520);
      check("valid_before_first", {15'd0, sample_valid}, 16'd0);
      run(1);
      check("first_valid", {15'd0, sample_valid}, 16'd1);
      check("first_left",  left_sample,  16'hA5C3);
      check("first_right", right_sample, 16'h1234);
      l_word = 16'h0001;
      r_word = 16'hFFFF;

      run(511);
      check("held_valid",   {15'd0, sample_valid}, 16'd1);
      check("no_overrun_yet", {15'd0, overrun},    16'd0);
      check("held_left",    left_sample, 16'hA5C3);
      run(1);
      check("ovr_flag",  {15'd0, overrun}, 16'd1);
      check("ovr_left",  left_sample,  16'h0001);
      check("ovr_right", right_sample, 16'hFFFF);
      check("ovr_valid", {15'd0, sample_valid}, 16'd1);

      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      check("pulse_valid_clr",  {15'd0, sample_valid}, 16'd0);
      check("pulse_ovr_sticky", {15'd0, overrun},      16'd1);

      sample_ready = 1'b1;
      run(511);
      check("third_valid",  {15'd0, sample_valid}, 16'd1);
      check("third_left",   left_sample,  16'h0001);
      check("third_right",  right_sample, 16'hFFFF);
      tick();
      check("third_taken",  {15'd0, sample_valid}, 16'd0);

      // Reset in the middle of a frame, then run the peak-meter stimulus with sample_ready held high.
      while (tcnt != 9'd300) tick();
      rst = 1'b1;
      l_word = 16'h8000;
      r_word = 16'h0000;
      tick();
      rst = 1'b0;
      check("mid_rst_clocks",  {13'd0, MCLK, SCK, LRCK}, 16'd0);
      check("mid_rst_left",    left_sample,  16'd0);
      check("mid_rst_right",   right_sample, 16'd0);
      check("mid_rst_valid",   {15'd0, sample_valid}, 16'd0);
      check("mid_rst_overrun", {15'd0, overrun},      16'd0);
      check("mid_rst_level",   {12'd0, level},        16'd0);
      run(520);
      check("rst_valid_before", {15'd0, sample_valid}, 16'd0);
      run(1);
      check("rst_first_valid", {15'd0, sample_valid}, 16'd1);
      check("rst_first_left",  left_sample,  16'h8000);
      check("rst_first_right", right_sample, 16'h0000);

      run(3 * 512 - 1);
      check("level_before_win", {12'd0, level}, 16'd0);
      run(1);
      check("level_full_scale", {12'd0, level}, LVL_A);
      check("load4_left",       left_sample,    16'h8000);
      l_word = 16'h0800;
      r_word = 16'h0800;

      run(512);
      check("level_holds",  {12'd0, level}, LVL_A);
      check("load5_left",   left_sample,  16'h0800);
      run(3 * 512);
      check("level_small",  {12'd0, level}, LVL_B);
      check("load8_left",   left_sample,  16'h0800);
      check("load8_right",  right_sample, 16'h0800);
      check("ready_high_no_overrun", {15'd0, overrun}, 16'd0);

      check("clock_outputs", 16'(clk_err), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
